truck_lane_scheduler: RTL and testbench

- Owns up to NUM_TRUCKS truck objects: horizontal position, lane Y, speed, direction and enable for each.
- Advances every truck's position once per frame on frame_tick, using an FSM that walks one truck per cycle through a single shared adder.
- Per pixel, arbitrates the single truck sprite ROM port between trucks: computes ROM DX/DY/dir for the granted truck and returns the palette index aligned to the pixel stream.
- Sits between the VGA DrawX/DrawY generator and the colour mapper.

---
 rtl/truck_lane_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_truck_lane_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truck_lane_scheduler.sv
// Truck slot table with a per-frame serial position updater (one slot per
// cycle through a shared adder) and a two-stage pixel hit / sprite ROM pipeline.
module truck_lane_scheduler #(
  parameter int unsigned NUM_TRUCKS = 4,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SPRITE_W   = 48,
  parameter int unsigned SPRITE_H   = 24,
  localparam int unsigned IDX_W     = (NUM_TRUCKS > 1) ? $clog2(NUM_TRUCKS) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_tick,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [9:0]       cfg_x,
  input  logic [9:0]       cfg_y,
  input  logic [3:0]       cfg_speed,
  input  logic             cfg_dir,
  input  logic             cfg_en,
  output logic [5:0]       rom_dx,
  output logic [5:0]       rom_dy,
  output logic             rom_dir,
  input  logic [7:0]       rom_data,
  output logic             truck_on,
  output logic [7:0]       truck_pixel,
  output logic             busy,
  output logic             tick_overrun
);

  localparam int unsigned W_TOT = SCREEN_W + SPRITE_W;
  localparam int unsigned XW    = 10;
  localparam int unsigned AW    = 11;
  localparam int unsigned SW    = 4;
  localparam int unsigned DW    = 6;
  localparam int unsigned PW    = 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_UPDATE = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;

  logic [XW-1:0]    xp_q  [NUM_TRUCKS];
  logic [XW-1:0]    xp_d  [NUM_TRUCKS];
  logic [XW-1:0]    y_q   [NUM_TRUCKS];
  logic [XW-1:0]    y_d   [NUM_TRUCKS];
  logic [SW-1:0]    spd_q [NUM_TRUCKS];
  logic [SW-1:0]    spd_d [NUM_TRUCKS];
  logic             dir_q [NUM_TRUCKS];
  logic             dir_d [NUM_TRUCKS];
  logic             en_q  [NUM_TRUCKS];
  logic             en_d  [NUM_TRUCKS];

  logic             hit_any_q, hit_any_d;
  logic [DW-1:0]    rom_dx_q, rom_dx_d;
  logic [DW-1:0]    rom_dy_q, rom_dy_d;
  logic             rom_dir_q, rom_dir_d;
  logic             on_q, on_d;
  logic [PW-1:0]    pix_q, pix_d;

  logic [XW-1:0]    cfg_x_wrap_c;
  logic [AW-1:0]    px_c;

  // Wrapping move of one truck by its speed around the W_TOT period.
  function automatic logic [XW-1:0] advance(input logic [XW-1:0] xp,
                                            input logic [SW-1:0] spd,
                                            input logic          dir);
    logic [AW-1:0] s;
    if (dir) begin
      s = AW'(xp) + AW'(spd);
      if (s >= AW'(W_TOT)) s = s - AW'(W_TOT);
    end else if (xp < XW'(spd)) begin
      s = AW'(xp) + AW'(W_TOT) - AW'(spd);
    end else begin
      s = AW'(xp) - AW'(spd);
    end
    return XW'(s);
  endfunction

  assign cfg_x_wrap_c = (cfg_x >= XW'(W_TOT)) ? cfg_x - XW'(W_TOT) : cfg_x;
  assign px_c         = AW'(DrawX) + AW'(SPRITE_W);

  // Update sequencer: a frame tick starts one pass over all slots.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_UPDATE;
          k_d     = '0;
        end
      end
      ST_UPDATE: begin
        if (frame_tick) ovr_d = 1'b1;
        if (k_q == IDX_W'(NUM_TRUCKS - 1)) begin
          state_d = ST_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_UPDATE);
  end

  // Slot table: a config write to the slot being updated overrides the move.
  always_comb begin
    xp_d  = xp_q;
    y_d   = y_q;
    spd_d = spd_q;
    dir_d = dir_q;
    en_d  = en_q;
    for (int i = 0; i < NUM_TRUCKS; i++) begin
      if ((state_q == ST_UPDATE) && (k_q == IDX_W'(i)) && en_q[i]) begin
        xp_d[i] = advance(xp_q[i], spd_q[i], dir_q[i]);
      end
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        xp_d[i]  = cfg_x_wrap_c;
        y_d[i]   = cfg_y;
        spd_d[i] = cfg_speed;
        dir_d[i] = cfg_dir;
        en_d[i]  = cfg_en;
      end
    end
  end

  // Pixel stage 1: lowest-index covering truck owns the ROM port.
  always_comb begin
    hit_any_d = 1'b0;
    rom_dx_d  = '0;
    rom_dy_d  = '0;
    rom_dir_d = 1'b0;
    for (int i = 0; i < NUM_TRUCKS; i++) begin
      if (!hit_any_d && en_q[i]
          && (AW'(xp_q[i]) <= px_c) && (px_c < AW'(xp_q[i]) + AW'(SPRITE_W))
          && (y_q[i] <= DrawY) && (AW'(DrawY) < AW'(y_q[i]) + AW'(SPRITE_H))) begin
        hit_any_d = 1'b1;
        rom_dx_d  = DW'(px_c - AW'(xp_q[i]));
        rom_dy_d  = DW'(DrawY - y_q[i]);
        rom_dir_d = dir_q[i];
      end
    end
  end

  // Pixel stage 2: transparent ROM entries never fall through to other trucks.
  always_comb begin
    pix_d = hit_any_q ? rom_data : '0;
    on_d  = hit_any_q && (rom_data != '0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < NUM_TRUCKS; i++) begin
        xp_q[i]  <= '0;
        y_q[i]   <= '0;
        spd_q[i] <= '0;
        dir_q[i] <= 1'b0;
        en_q[i]  <= 1'b0;
      end
      hit_any_q <= 1'b0;
      rom_dx_q  <= '0;
      rom_dy_q  <= '0;
      rom_dir_q <= 1'b0;
      on_q      <= 1'b0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      xp_q      <= xp_d;
      y_q       <= y_d;
      spd_q     <= spd_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      hit_any_q <= hit_any_d;
      rom_dx_q  <= rom_dx_d;
      rom_dy_q  <= rom_dy_d;
      rom_dir_q <= rom_dir_d;
      on_q      <= on_d;
      pix_q     <= pix_d;
    end
  end

  assign rom_dx       = rom_dx_q;
  assign rom_dy       = rom_dy_q;
  assign rom_dir      = rom_dir_q;
  assign truck_on     = on_q;
  assign truck_pixel  = pix_q;
  assign busy         = busy_q;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_truck_lane_scheduler.sv
// Scoreboard bench for truck_lane_scheduler: screen-space reference model,
// expectations queued per clock edge and checked by an independent monitor.
module tb_truck_lane_scheduler;

  localparam int N   = 4;
  localparam int SPW = 48;
  localparam int SPH = 24;
  localparam int WT  = 688;

  logic       Clk, Reset_n, frame_tick;
  logic [9:0] DrawX, DrawY;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [9:0] cfg_x, cfg_y;
  logic [3:0] cfg_speed;
  logic       cfg_dir, cfg_en;
  logic [5:0] rom_dx, rom_dy;
  logic       rom_dir;
  logic [7:0] rom_data;
  logic       truck_on;
  logic [7:0] truck_pixel;
  logic       busy, tick_overrun;

  truck_lane_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_speed(cfg_speed), .cfg_dir(cfg_dir), .cfg_en(cfg_en),
    .rom_dx(rom_dx), .rom_dy(rom_dy), .rom_dir(rom_dir), .rom_data(rom_data),
    .truck_on(truck_on), .truck_pixel(truck_pixel),
    .busy(busy), .tick_overrun(tick_overrun)
  );

  // Sprite ROM contents: column 0 and every 12th diagonal are transparent.
  function automatic logic [7:0] rom_fn(input int dx, input int dy, input int dir);
    if (dx == 0) return 8'd0;
    return 8'((dx + dy + dir) % 12);
  endfunction

  assign rom_data = rom_fn(int'(rom_dx), int'(rom_dy), int'(rom_dir));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {int due; int dx; int dy; int dir; int bsy; int ovr;} rom_exp_t;
  typedef struct {int due; int on; int pix;} pix_exp_t;

  rom_exp_t rq[$];
  pix_exp_t pq[$];
  int checks = 0;
  int failures = 0;
  int nedge = 0;
  int mon_edge = 0;
  bit model_on = 0;

  int m_xp[N], m_y[N], m_spd[N], m_dir[N], m_en[N];
  int pass_t;
  int m_ovr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_xp[i] = 0; m_y[i] = 0; m_spd[i] = 0; m_dir[i] = 0; m_en[i] = 0;
    end
    pass_t = -1;
    m_ovr  = 0;
  endtask

  // Reference behaviour for one clock edge e, using the inputs currently driven.
  task automatic model_edge(input int e);
    rom_exp_t r;
    pix_exp_t p;
    int g, j, k;
    bit in_pass;
    g = -1;
    for (int i = 0; i < N; i++) begin
      if (g < 0 && m_en[i] != 0
          && int'(DrawX) >= m_xp[i] - SPW && int'(DrawX) < m_xp[i]
          && int'(DrawY) >= m_y[i] && int'(DrawY) < m_y[i] + SPH) g = i;
    end
    r.due = e;
    if (g >= 0) begin
      r.dx  = int'(DrawX) - (m_xp[g] - SPW);
      r.dy  = int'(DrawY) - m_y[g];
      r.dir = m_dir[g];
    end else begin
      r.dx = 0; r.dy = 0; r.dir = 0;
    end
    p.due = e + 1;
    p.pix = (g >= 0) ? int'(rom_fn(r.dx, r.dy, r.dir)) : 0;
    p.on  = (p.pix != 0) ? 1 : 0;

    // A pass accepted at edge T moves slot j at edge T+1+j.
    in_pass = (pass_t >= 0) && (e >= pass_t + 1) && (e <= pass_t + N);
    if (in_pass) begin
      j = e - pass_t - 1;
      if (m_en[j] != 0 && !(cfg_we && int'(cfg_idx) == j))
        m_xp[j] = (m_dir[j] != 0) ? (m_xp[j] + m_spd[j]) % WT
                                  : (m_xp[j] - m_spd[j] + WT) % WT;
    end
    if (frame_tick) begin
      if (in_pass) m_ovr = 1;
      else pass_t = e;
    end
    if (cfg_we) begin
      k = int'(cfg_idx);
      m_xp[k]  = int'(cfg_x) % WT;
      m_y[k]   = int'(cfg_y);
      m_spd[k] = int'(cfg_speed);
      m_dir[k] = int'(cfg_dir);
      m_en[k]  = int'(cfg_en);
    end
    r.bsy = (pass_t >= 0 && e >= pass_t && e <= pass_t + N - 1) ? 1 : 0;
    r.ovr = m_ovr;
    rq.push_back(r);
    pq.push_back(p);
  endtask

  task automatic step();
    if (model_on) model_edge(nedge + 1);
    @(posedge Clk);
    nedge++;
    @(negedge Clk);
    frame_tick = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cfg(input int idx, input int x, input int y, input int spd,
                     input int dir, input int en);
    cfg_we    = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_x     = 10'(x);
    cfg_y     = 10'(y);
    cfg_speed = 4'(spd);
    cfg_dir   = 1'(dir);
    cfg_en    = 1'(en);
  endtask

  task automatic rand_cycle();
    int s, v;
    s = int'($urandom_range(0, N - 1));
    if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 719));
    else v = m_xp[s] - 50 + int'($urandom_range(0, 52));
    if (v < 0) v = 0;
    DrawX = 10'(v);
    if ($urandom_range(0, 7) == 0) DrawY = 10'($urandom_range(0, 479));
    else DrawY = 10'(m_y[s] + int'($urandom_range(0, 29)));
    if ($urandom_range(0, 15) == 0)
      cfg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 120)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0);
    if ($urandom_range(0, 24) == 0) frame_tick = 1'b1;
    step();
  endtask

  // Monitor: compare whatever expectations fall due at this edge.
  rom_exp_t mr;
  pix_exp_t mp;
  always @(posedge Clk) begin
    #1;
    mon_edge++;
    while (rq.size() > 0 && rq[0].due <= mon_edge) begin
      mr = rq.pop_front();
      if (mr.due < mon_edge) chk("rom_sched", mr.due, mon_edge);
      else begin
        chk("rom_dx", int'(rom_dx), mr.dx);
        chk("rom_dy", int'(rom_dy), mr.dy);
        chk("rom_dir", int'(rom_dir), mr.dir);
        chk("busy", int'(busy), mr.bsy);
        chk("tick_overrun", int'(tick_overrun), mr.ovr);
      end
    end
    while (pq.size() > 0 && pq[0].due <= mon_edge) begin
      mp = pq.pop_front();
      if (mp.due < mon_edge) chk("pix_sched", mp.due, mon_edge);
      else begin
        chk("truck_on", int'(truck_on), mp.on);
        chk("truck_pixel", int'(truck_pixel), mp.pix);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; DrawX = '0; DrawY = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
    cfg_speed = '0; cfg_dir = 1'b0; cfg_en = 1'b0;
    model_reset();
    idle(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    chk("rst_truck_on", int'(truck_on), 0);
    chk("rst_pixel", int'(truck_pixel), 0);
    chk("rst_rom_dx", int'(rom_dx), 0);
    chk("rst_rom_dy", int'(rom_dy), 0);
    chk("rst_rom_dir", int'(rom_dir), 0);
    Reset_n  = 1'b1;
    model_on = 1;

    // Single truck: interior, left edge (transparent column) and borders.
    cfg(0, 100, 200, 0, 1, 1); step();
    DrawX = 10'd60; DrawY = 10'd205; step();
    DrawX = 10'd52; step();
    DrawX = 10'd99; DrawY = 10'd223; step();
    DrawX = 10'd100; step();
    DrawX = 10'd60; DrawY = 10'd224; step();
    DrawX = 10'd51; DrawY = 10'd210; step();

    // Wrap in both directions over one update pass.
    cfg(0, 686, 200, 3, 1, 1); step();
    cfg(1, 1, 300, 3, 0, 1); step();
    frame_tick = 1'b1; step();
    idle(6);
    DrawX = 10'd0; DrawY = 10'd210; step();
    DrawX = 10'd640; DrawY = 10'd310; step();
    DrawX = 10'd685; step();
    idle(2);

    // Overlap priority, then the lower-priority truck after disabling slot 0.
    cfg(1, 0, 0, 0, 0, 0); step();
    cfg(0, 100, 200, 0, 0, 1); step();
    cfg(2, 110, 205, 0, 1, 1); step();
    cfg(3, 0, 0, 0, 0, 0); step();
    DrawX = 10'd70; DrawY = 10'd210; step(); step();
    cfg(0, 100, 200, 0, 0, 0); step(); step(); step();

    // Tick during the pass, plus a config write racing slot 2's update.
    cfg(2, 110, 205, 5, 1, 1); step();
    frame_tick = 1'b1; step();
    step();
    frame_tick = 1'b1; step();
    cfg(2, 500, 205, 7, 1, 1); step();
    idle(4);
    DrawX = 10'd470; DrawY = 10'd210; step();
    DrawX = 10'd455; step();
    idle(2);

    repeat (3000) rand_cycle();
    idle(6);

    // Asynchronous reset in the middle of an update pass.
    cfg(0, 300, 100, 2, 1, 1);
    DrawX = 10'd271; DrawY = 10'd105; step();
    frame_tick = 1'b1; step();
    step();
    model_on = 0;
    rq.delete();
    pq.delete();
    Reset_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_truck_on", int'(truck_on), 0);
    chk("arst_overrun", int'(tick_overrun), 0);
    chk("arst_pixel", int'(truck_pixel), 0);
    idle(2);
    Reset_n = 1'b1;
    model_reset();
    model_on = 1;
    DrawX = 10'd271; DrawY = 10'd105; step();
    for (int c = 0; c < 40; c++) begin
      DrawX = 10'($urandom_range(0, 700));
      DrawY = 10'($urandom_range(0, 300));
      if (c == 10) frame_tick = 1'b1;
      step();
    end

    model_on = 0;
    idle(3);
    chk("drain", rq.size() + pq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
